// File: rtl/sram_row_bw_dwsn.sv
// Row-wide SRAM bank with bit-write mask, per-segment write-disable and per-word parity.
// Rows are zeroed by a sequencer after reset; reads return after a fixed pipeline latency.
module sram_row_bw_dwsn #(
   parameter int WIDTH      = 32,
   parameter int NUMWRDS    = 4,
   parameter int NUMSROW    = 256,
   parameter int BITSROW    = 8,
   parameter int SEGW       = 72,
   parameter int BITDWSN    = 4,
   parameter int SRAM_DELAY = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic [BITSROW-1:0]         mem_addr,
   input  logic [NUMWRDS*WIDTH-1:0]   mem_bw,
   input  logic [BITDWSN-1:0]         mem_dwsn,
   input  logic [NUMWRDS*WIDTH-1:0]   mem_din,
   input  logic [NUMWRDS-1:0]         err_inj,
   output logic [NUMWRDS*WIDTH-1:0]   mem_dout,
   output logic [NUMWRDS-1:0]         mem_serr,
   output logic                       mem_vld,
   output logic                       ready,
   output logic                       cmd_err
);

   localparam int ROWW = NUMWRDS * WIDTH;
   localparam int GATED = BITDWSN * SEGW;
   localparam logic [BITSROW:0] ROW_LIM = (BITSROW + 1)'(NUMSROW);
   localparam logic [BITSROW-1:0] LAST_ROW = BITSROW'(NUMSROW - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t               state_q, state_d;
   logic [BITSROW-1:0]   cnt_q, cnt_d;

   logic [ROWW-1:0]      mem_q [NUMSROW];
   logic [NUMWRDS-1:0]   par_q [NUMSROW];

   logic [ROWW-1:0]      pd_q [SRAM_DELAY];
   logic [NUMWRDS-1:0]   pp_q [SRAM_DELAY];
   logic [SRAM_DELAY-1:0] pv_q;
   logic [SRAM_DELAY-1:0] pz_q;

   logic [ROWW-1:0]      mem_dout_q;
   logic [NUMWRDS-1:0]   mem_serr_q;
   logic                 mem_vld_q;
   logic                 cmd_err_q;

   logic                 run;
   logic                 addr_ok;
   logic                 rd_go;
   logic                 wr_go;
   logic                 bad_cmd;
   logic [BITSROW-1:0]   addr_idx;

   logic [ROWW-1:0]      old_row;
   logic [NUMWRDS-1:0]   old_par;
   logic [ROWW-1:0]      eff_mask;
   logic [ROWW-1:0]      new_row;
   logic [NUMWRDS-1:0]   touched;
   logic [NUMWRDS-1:0]   new_par;
   logic [NUMWRDS-1:0]   rd_par;

   logic                 we;
   logic [BITSROW-1:0]   we_idx;
   logic [ROWW-1:0]      we_row;
   logic [NUMWRDS-1:0]   we_par;

   assign run      = (state_q == RUN);
   assign addr_ok  = ({1'b0, mem_addr} < ROW_LIM);
   assign addr_idx = addr_ok ? mem_addr : '0;
   assign rd_go    = run & mem_read;
   assign wr_go    = run & mem_write & ~mem_read & addr_ok;
   assign bad_cmd  = (mem_read | mem_write) & (~run | (mem_read & mem_write) | ~addr_ok);

   assign old_row  = mem_q[addr_idx];
   assign old_par  = par_q[addr_idx];

   // Bits above the last segment have no disable control and follow mem_bw alone.
   for (genvar gi = 0; gi < ROWW; gi++) begin : g_mask
      if (gi >= GATED) begin : g_free
         assign eff_mask[gi] = mem_bw[gi];
      end else begin : g_seg
         assign eff_mask[gi] = mem_bw[gi] & ~mem_dwsn[gi / SEGW];
      end
   end

   assign new_row = (old_row & ~eff_mask) | (mem_din & eff_mask);

   for (genvar gi = 0; gi < NUMWRDS; gi++) begin : g_word
      assign touched[gi] = |eff_mask[gi*WIDTH +: WIDTH];
      assign new_par[gi] = touched[gi] ? (^new_row[gi*WIDTH +: WIDTH]) ^ err_inj[gi]
                                       : old_par[gi];
      assign rd_par[gi]  = ^pd_q[SRAM_DELAY-1][gi*WIDTH +: WIDTH];
   end

   // One shared write port: the clearing sequencer owns it until RUN.
   assign we     = ~run | wr_go;
   assign we_idx = run ? addr_idx : cnt_q;
   assign we_row = run ? new_row : '0;
   assign we_par = run ? new_par : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ROW) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[we_idx] <= we_row;
         par_q[we_idx] <= we_par;
      end
      pd_q[0] <= mem_q[addr_idx];
      pp_q[0] <= par_q[addr_idx];
      for (int k = 1; k < SRAM_DELAY; k++) begin
         pd_q[k] <= pd_q[k-1];
         pp_q[k] <= pp_q[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= INIT;
         cnt_q      <= '0;
         pv_q       <= '0;
         pz_q       <= '0;
         mem_dout_q <= '0;
         mem_serr_q <= '0;
         mem_vld_q  <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pv_q[0] <= rd_go;
         pz_q[0] <= ~addr_ok;
         for (int k = 1; k < SRAM_DELAY; k++) begin
            pv_q[k] <= pv_q[k-1];
            pz_q[k] <= pz_q[k-1];
         end
         mem_vld_q <= pv_q[SRAM_DELAY-1];
         // Out-of-range reads still complete, but with zero data and no parity flags.
         if (pv_q[SRAM_DELAY-1]) begin
            mem_dout_q <= pz_q[SRAM_DELAY-1] ? '0 : pd_q[SRAM_DELAY-1];
            mem_serr_q <= pz_q[SRAM_DELAY-1] ? '0 : (pp_q[SRAM_DELAY-1] ^ rd_par);
         end
         cmd_err_q <= cmd_err_q | bad_cmd;
      end
   end

   assign mem_dout = mem_dout_q;
   assign mem_serr = mem_serr_q;
   assign mem_vld  = mem_vld_q;
   assign ready    = run;
   assign cmd_err  = cmd_err_q;

endmodule
